// File: rtl/l2c_dram_access_ctrl.sv
// Request-side controller for the L2 data array (512 x 256b byte-strobed SDP RAM, 1-cycle read).
// Latency: read accepted at T, RAM data at T+1, response visible at T+2; writes land in the RAM at T.
// Backpressure: reads (and writes when acks are on) need a free response slot; a pop does not return credit until the next cycle.
//
// Ports:
//   clk_i, rst_i (async, active-high); init_done_o high once the optional zero-fill has finished.
//   req_*  : valid/ready request channel (we, addr, wdata, wstrb, tag).
//   rsp_*  : valid/ready response channel (rdata, tag, wr); held stable while stalled.
//   ram_*  : write/read ports of the data-array macro; ram_rdata_i valid the cycle after ram_re_o.
// Build option: define L2C_DRAM_WACK_EN to make writes return an ack response (rsp_wr_o=1, rdata=0)
// and consume credit like reads; otherwise writes are silent and rsp_wr_o is always 0.
module l2c_dram_access_ctrl #(
    parameter int TAG_W     = 4,
    parameter int RSP_DEPTH = 4,
    parameter int ZERO_INIT = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    output logic             init_done_o,
    input  logic             req_vld_i,
    output logic             req_rdy_o,
    input  logic             req_we_i,
    input  logic [8:0]       req_addr_i,
    input  logic [255:0]     req_wdata_i,
    input  logic [31:0]      req_wstrb_i,
    input  logic [TAG_W-1:0] req_tag_i,
    output logic             rsp_vld_o,
    input  logic             rsp_rdy_i,
    output logic [255:0]     rsp_rdata_o,
    output logic [TAG_W-1:0] rsp_tag_o,
    output logic             rsp_wr_o,
    output logic             ram_we_o,
    output logic [8:0]       ram_waddr_o,
    output logic [255:0]     ram_wdata_o,
    output logic [31:0]      ram_wstrob_o,
    output logic             ram_re_o,
    output logic [8:0]       ram_raddr_o,
    input  logic [255:0]     ram_rdata_i
);

    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = RSP_DEPTH[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

    typedef enum logic {ST_INIT, ST_RUN} state_t;
    localparam state_t RST_STATE = (ZERO_INIT != 0) ? ST_INIT : ST_RUN;

    typedef struct packed {
        logic             wr;
        logic [TAG_W-1:0] tag;
        logic [255:0]     data;
    } rsp_t;

    state_t           state_q, state_d;
    logic [8:0]       init_cnt_q, init_cnt_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             inflight_q, inflight_d;
    logic [TAG_W-1:0] inflight_tag_q, inflight_tag_d;
`ifdef L2C_DRAM_WACK_EN
    logic             inflight_wr_q, inflight_wr_d;
`endif
    rsp_t             mem_q [RSP_DEPTH];
    rsp_t             mem_d [RSP_DEPTH];

    logic             live, run, credit_ok, accept, push, pop, push_wr;
    logic [CNT_W-1:0] occ;
    rsp_t             head;

    always_comb begin
        state_d        = state_q;
        init_cnt_d     = init_cnt_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        cnt_d          = cnt_q;
        inflight_d     = 1'b0;
        inflight_tag_d = inflight_tag_q;
`ifdef L2C_DRAM_WACK_EN
        inflight_wr_d  = 1'b0;
`endif
        mem_d          = mem_q;

        // Outputs are gated while reset is held so they read 0 regardless of the reset state.
        live = !rst_i;
        run  = live && (state_q == ST_RUN);

        // A read issued last cycle already owns a slot even though its data is not in the FIFO yet.
        occ       = cnt_q + {{(CNT_W-1){1'b0}}, inflight_q};
        credit_ok = (occ < DEPTH_C);

`ifdef L2C_DRAM_WACK_EN
        req_rdy_o = run && credit_ok;
`else
        req_rdy_o = run && (req_we_i || credit_ok);
`endif
        accept      = req_vld_i && req_rdy_o;
        init_done_o = run;

        ram_we_o     = accept && req_we_i;
        ram_waddr_o  = req_addr_i;
        ram_wdata_o  = req_wdata_i;
        ram_wstrob_o = req_wstrb_i;
        ram_re_o     = accept && !req_we_i;
        ram_raddr_o  = req_addr_i;

        if (live && (state_q == ST_INIT)) begin
            ram_we_o     = 1'b1;
            ram_waddr_o  = init_cnt_q;
            ram_wdata_o  = '0;
            ram_wstrob_o = '1;
            init_cnt_d   = init_cnt_q + 9'd1;
            if (init_cnt_q == 9'd511) begin
                state_d = ST_RUN;
            end
        end

        if (accept) begin
            inflight_tag_d = req_tag_i;
`ifdef L2C_DRAM_WACK_EN
            inflight_d     = 1'b1;
            inflight_wr_d  = req_we_i;
`else
            inflight_d     = !req_we_i;
`endif
        end

`ifdef L2C_DRAM_WACK_EN
        push_wr = inflight_wr_q;
`else
        push_wr = 1'b0;
`endif
        push = inflight_q;
        head = mem_q[rd_ptr_q];
        rsp_vld_o   = (cnt_q != '0);
        rsp_rdata_o = head.data;
        rsp_tag_o   = head.tag;
        rsp_wr_o    = head.wr;
        pop = rsp_vld_o && rsp_rdy_i;

        if (push) begin
            mem_d[wr_ptr_q] = '{wr: push_wr, tag: inflight_tag_q, data: (push_wr ? '0 : ram_rdata_i)};
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !pop) begin
            cnt_d = cnt_q + CNT_ONE;
        end else if (pop && !push) begin
            cnt_d = cnt_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q        <= RST_STATE;
            init_cnt_q     <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            cnt_q          <= '0;
            inflight_q     <= 1'b0;
            inflight_tag_q <= '0;
`ifdef L2C_DRAM_WACK_EN
            inflight_wr_q  <= 1'b0;
`endif
            for (int i = 0; i < RSP_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            init_cnt_q     <= init_cnt_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            cnt_q          <= cnt_d;
            inflight_q     <= inflight_d;
            inflight_tag_q <= inflight_tag_d;
`ifdef L2C_DRAM_WACK_EN
            inflight_wr_q  <= inflight_wr_d;
`endif
            mem_q          <= mem_d;
        end
    end

`ifndef SYNTHESIS
    // Credit accounting guarantees a slot for every in-flight response.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(push && !pop && (cnt_q == DEPTH_C)))
                else $error("response fifo overflow");
        end
    end
`endif

endmodule

// File: tb/tb_l2c_dram_access_ctrl.sv
module tb_l2c_dram_access_ctrl;

    typedef struct packed {
        logic         wr;
        logic [3:0]   tag;
        logic [255:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         init_done;
    logic         req_vld = 1'b0;
    logic         req_rdy;
    logic         req_we = 1'b0;
    logic [8:0]   req_addr = '0;
    logic [255:0] req_wdata = '0;
    logic [31:0]  req_wstrb = '0;
    logic [3:0]   req_tag = '0;
    logic         rsp_vld;
    logic         rsp_rdy = 1'b1;
    logic [255:0] rsp_rdata;
    logic [3:0]   rsp_tag;
    logic         rsp_wr;
    logic         ram_we;
    logic [8:0]   ram_waddr;
    logic [255:0] ram_wdata;
    logic [31:0]  ram_wstrob;
    logic         ram_re;
    logic [8:0]   ram_raddr;
    logic [255:0] ram_rdata;

    logic [255:0] ram [512];
    logic [255:0] ref_mem [512];
    exp_t         exp_q [$];

    int errors = 0;
    int checks = 0;
    int pops   = 0;
    int n, n_acc, guard, sweep_err, pops_base;
    logic [255:0] aa_line, mixed_line;

    always #5 clk = ~clk;

    l2c_dram_access_ctrl #(.TAG_W(4), .RSP_DEPTH(4), .ZERO_INIT(1)) dut (
        .clk_i(clk), .rst_i(rst), .init_done_o(init_done),
        .req_vld_i(req_vld), .req_rdy_o(req_rdy), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
        .req_tag_i(req_tag),
        .rsp_vld_o(rsp_vld), .rsp_rdy_i(rsp_rdy), .rsp_rdata_o(rsp_rdata),
        .rsp_tag_o(rsp_tag), .rsp_wr_o(rsp_wr),
        .ram_we_o(ram_we), .ram_waddr_o(ram_waddr), .ram_wdata_o(ram_wdata),
        .ram_wstrob_o(ram_wstrob), .ram_re_o(ram_re), .ram_raddr_o(ram_raddr),
        .ram_rdata_i(ram_rdata)
    );

    // Behavioural data-array macro: byte-strobed write, registered 1-cycle read.
    always @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 32; b++) begin
                if (ram_wstrob[b]) ram[ram_waddr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
            end
        end
        if (ram_re) ram_rdata <= ram[ram_raddr];
    end

    task automatic chk(input string name, input logic [263:0] obs, input logic [263:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic drv(input logic vld, input logic we, input logic [8:0] addr,
                       input logic [255:0] wd, input logic [31:0] st, input logic [3:0] tag);
        req_vld   = vld;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        req_wstrb = st;
        req_tag   = tag;
    endtask

    task automatic idle();
        drv(1'b0, 1'b0, 9'd0, '0, '0, 4'd0);
    endtask

    // One clock: scoreboard bookkeeping at the negedge, return 1 time unit after the posedge.
    task automatic cyc();
        exp_t e;
        @(negedge clk);
        if (req_vld && req_rdy) begin
            if (req_we) begin
                for (int b = 0; b < 32; b++) begin
                    if (req_wstrb[b]) ref_mem[req_addr][b*8 +: 8] = req_wdata[b*8 +: 8];
                end
`ifdef L2C_DRAM_WACK_EN
                e = '{wr: 1'b1, tag: req_tag, data: '0};
                exp_q.push_back(e);
`endif
            end else begin
                e = '{wr: 1'b0, tag: req_tag, data: ref_mem[req_addr]};
                exp_q.push_back(e);
            end
        end
        if (rsp_vld && rsp_rdy) begin
            pops++;
            chk("rsp_expected_pending", 264'(exp_q.size() != 0), 264'(1));
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("rsp_wr_tag_data", {rsp_wr, rsp_tag, rsp_rdata}, e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ref_mem[i] = '0;
        aa_line    = {32{8'hAA}};
        mixed_line = {{28{8'hAA}}, {4{8'h55}}};

        // Reset state and reset in the middle of the zero-fill.
        #2;
        chk("rst_init_done", init_done, 0);
        chk("rst_req_rdy",   req_rdy,   0);
        chk("rst_rsp_vld",   rsp_vld,   0);
        chk("rst_ram_we",    ram_we,    0);
        cyc(); cyc();
        rst = 1'b0;
        #1;
        n = 0;
        while (!(ram_we && ram_waddr == 9'd100) && n < 200) begin
            cyc();
            n++;
        end
        chk("init_cnt100_window", n, 100);
        rst = 1'b1;
        #1;
        chk("midrst_init_done", init_done, 0);
        chk("midrst_req_rdy",   req_rdy,   0);
        chk("midrst_rsp_vld",   rsp_vld,   0);
        chk("midrst_rsp_wr",    rsp_wr,    0);
        chk("midrst_ram_we",    ram_we,    0);
        chk("midrst_ram_re",    ram_re,    0);
        cyc(); cyc();
        rst = 1'b0;
        #1;
        n = 0;
        sweep_err = 0;
        while (!init_done && n < 700) begin
            if (!(ram_we && ram_waddr == n[8:0] && ram_wstrob == '1 && ram_wdata == '0)) sweep_err++;
            cyc();
            n++;
        end
        chk("init_len_512", n, 512);
        chk("init_sweep", sweep_err, 0);

        // Read of the last line after zero-fill: data 0, response at T+2.
        drv(1'b1, 1'b0, 9'h1FF, '0, '0, 4'd1);
        #1;
        chk("rd_rdy_after_init", req_rdy, 1);
        chk("rd_ram_re", {ram_re, ram_we, ram_raddr}, {1'b1, 1'b0, 9'h1FF});
        cyc();
        idle();
        #1;
        chk("rsp_not_at_t1", rsp_vld, 0);
        cyc();
        #1;
        chk("rsp_at_t2", rsp_vld, 1);
        chk("rsp_zero_data", rsp_rdata, 0);
        cyc();

        // Full-line write then back-to-back read of the same line.
        drv(1'b1, 1'b1, 9'h1A5, aa_line, '1, 4'd0);
        #1;
        chk("wr_ram_port", {ram_we, ram_re, ram_waddr, ram_wstrob}, {1'b1, 1'b0, 9'h1A5, 32'hFFFF_FFFF});
        chk("wr_ram_data", ram_wdata, aa_line);
        cyc();
        drv(1'b1, 1'b0, 9'h1A5, '0, '0, 4'd3);
        cyc();
        idle();
        cyc();
        #1;
        chk("rd_after_wr_vld_tag", {rsp_vld, rsp_tag}, {1'b1, 4'd3});
        chk("rd_after_wr_data", rsp_rdata, aa_line);
        cyc();

        // Partial strobe keeps unstrobed bytes.
        drv(1'b1, 1'b1, 9'h010, aa_line, '1, 4'd0);
        cyc();
        drv(1'b1, 1'b1, 9'h010, {32{8'h55}}, 32'h0000_000F, 4'd0);
        cyc();
        drv(1'b1, 1'b0, 9'h010, '0, '0, 4'd4);
        cyc();
        idle();
        cyc();
        #1;
        chk("partial_strobe_data", rsp_rdata, mixed_line);
        cyc();
        while (exp_q.size() != 0 && guard < 20) begin cyc(); guard++; end

        // Credit limit with the response side stalled.
        pops_base = pops;
        rsp_rdy = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 10; i++) begin
            drv(1'b1, 1'b0, 9'h1A5, '0, '0, n_acc[3:0]);
            #1;
            if (req_rdy) n_acc++;
            cyc();
        end
        chk("stall_reads_accepted", n_acc, 4);
        drv(1'b1, 1'b0, 9'h1A5, '0, '0, n_acc[3:0]);
        #1;
        chk("stall_read_rdy_low", req_rdy, 0);
        chk("stall_head", {rsp_vld, rsp_tag}, {1'b1, 4'd0});
        drv(1'b1, 1'b1, 9'h150, {32{8'h77}}, '1, 4'd9);
        #1;
`ifdef L2C_DRAM_WACK_EN
        chk("stall_write_rdy", req_rdy, 0);
`else
        chk("stall_write_rdy", req_rdy, 1);
`endif
        cyc();
        idle();
        cyc();
        #1;
        chk("stall_head_stable", {rsp_vld, rsp_tag, rsp_rdata}, {1'b1, 4'd0, aa_line});
        rsp_rdy = 1'b1;
        guard = 0;
        while (n_acc < 8 && guard < 40) begin
            drv(1'b1, 1'b0, 9'h1A5, '0, '0, n_acc[3:0]);
            #1;
            if (req_rdy) n_acc++;
            cyc();
            guard++;
        end
        chk("stream_reads_accepted", n_acc, 8);
        idle();
        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin cyc(); guard++; end
        chk("stream_drained", exp_q.size(), 0);
        chk("stream_pop_count", pops - pops_base, 8);

        // Write followed by read: ack ordering depends on the build option.
        pops_base = pops;
        drv(1'b1, 1'b1, 9'h0F0, {32{8'h3C}}, '1, 4'd5);
        cyc();
        drv(1'b1, 1'b0, 9'h0F0, '0, '0, 4'd6);
        cyc();
        idle();
        guard = 0;
        while (exp_q.size() != 0 && guard < 20) begin cyc(); guard++; end
        cyc();
        chk("wack_drained", exp_q.size(), 0);
`ifdef L2C_DRAM_WACK_EN
        chk("wack_rsp_count", pops - pops_base, 2);
`else
        chk("wack_rsp_count", pops - pops_base, 1);
`endif
        chk("final_rsp_vld", rsp_vld, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
